// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Row-scanning controller for a 4x4 DTMF keypad. One row is driven low at a
//   time and the synchronized columns are sampled at the end of each row dwell.
//   Presses and releases are debounced before they are accepted. The result is
//   a single 5-bit word for a PIO in_port, so software only has to poll one
//   register.
//
// Optional build macro: KEYPAD_IRQ_EN adds a sticky irq output with an ack input.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   col_in     keypad columns, active-low, asynchronous (external pull-ups)
//   row_out    row drive, active-low, exactly one row low
//   key_code   [4] key held, [3:0] code of last accepted key
//   key_event  one-clock pulse per accepted press
//   irq_ack    (KEYPAD_IRQ_EN) clears irq
//   irq        (KEYPAD_IRQ_EN) set by key_event, held until irq_ack
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [4:0] key_code,
`ifdef KEYPAD_IRQ_EN
    output logic       key_event,
    input  logic       irq_ack,
    output logic       irq
`else
    output logic       key_event
`endif
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE_P, HELD} state_t;

    state_t        state, state_nxt;
    logic [3:0]    col_m, col_s;
    logic [1:0]    row_idx;
    logic [DW-1:0] dwell;
    logic [SW-1:0] stab;
    logic [3:0]    cand_pat;
    logic [3:0]    cand_code;

    logic sample_pt, stab_last, col_idle, match;
    logic accept, release_ok, row_adv, latch_cand;

    // Lowest low column wins when several columns are pulled down together.
    function automatic logic [1:0] col_sel(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    // Two-flop synchronizer; idles high to match the pull-ups.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    assign sample_pt = (dwell == DWELL_LAST);
    assign stab_last = (stab == STAB_LAST);
    assign col_idle  = (col_s == 4'hF);
    assign match     = (col_s == cand_pat);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SCAN;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:       if (sample_pt && !col_idle) state_nxt = DEBOUNCE_P;
            DEBOUNCE_P: if (!match)                 state_nxt = SCAN;
                        else if (stab_last)         state_nxt = HELD;
            HELD:       if (col_idle && stab_last)  state_nxt = SCAN;
            default:                                state_nxt = SCAN;
        endcase
    end

    // FSM: outputs and datapath strobes
    always_comb begin
        latch_cand = (state == SCAN) && sample_pt && !col_idle;
        accept     = (state == DEBOUNCE_P) && match && stab_last;
        release_ok = (state == HELD) && col_idle && stab_last;
        // Leaving a row for any reason moves the scan on to the next row.
        row_adv    = ((state == SCAN) && sample_pt && col_idle) ||
                     ((state == DEBOUNCE_P) && !match) ||
                     release_ok;
        row_out    = ~(4'b0001 << row_idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_idx   <= 2'd0;
            dwell     <= '0;
            stab      <= '0;
            cand_pat  <= 4'hF;
            cand_code <= 4'h0;
            key_code  <= 5'h00;
            key_event <= 1'b0;
        end else begin
            if (row_adv) row_idx <= row_idx + 2'd1;

            if (state == SCAN && !sample_pt) dwell <= dwell + 1'b1;
            else                             dwell <= '0;

            // Stability counter: in DEBOUNCE_P it counts matching clocks, in
            // HELD it counts idle clocks and restarts on any low column.
            case (state)
                DEBOUNCE_P: stab <= (!match || stab_last) ? '0 : stab + 1'b1;
                HELD:       stab <= (!col_idle || stab_last) ? '0 : stab + 1'b1;
                default:    stab <= '0;
            endcase

            if (latch_cand) begin
                cand_pat  <= col_s;
                cand_code <= key_lut(row_idx, col_sel(col_s));
            end

            if (accept)          key_code    <= {1'b1, cand_code};
            else if (release_ok) key_code[4] <= 1'b0;

            key_event <= accept;
        end
    end

`ifdef KEYPAD_IRQ_EN
    // Set has priority over a coincident ack so no press is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       irq <= 1'b0;
        else if (key_event) irq <= 1'b1;
        else if (irq_ack)   irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [4:0] key_code;
    logic       key_event;
`ifdef KEYPAD_IRQ_EN
    logic       irq_ack = 1'b0;
    logic       irq;
`endif

    logic [3:0][3:0] pressed = '0;   // [row][col]

    int n_chk  = 0;
    int n_pass = 0;
    int ev_cnt = 0;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
`ifdef KEYPAD_IRQ_EN
        .key_event(key_event),
        .irq_ack  (irq_ack),
        .irq      (irq)
`else
        .key_event(key_event)
`endif
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !row_out[r]) col_in[c] = 1'b0;
    end

    // Count pulses on posedge: reads the value from the previous edge.
    always @(posedge clk) if (key_event) ev_cnt <= ev_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_code(input string tag, input logic [4:0] exp, input int budget);
        int n = 0;
        while (key_code !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, key_code, exp);
    endtask

    initial begin
        int ev0, ev1, bad;

        cyc(2);
        chk("rst_row", row_out, 4'b1110);
        chk("rst_code", key_code, 5'h00);
        chk("rst_ev", key_event, 1'b0);
`ifdef KEYPAD_IRQ_EN
        chk("rst_irq", irq, 1'b0);
`endif
        reset_n = 1'b1;
        cyc(1);

        // '5' : row1 col1
        ev0 = ev_cnt;
        pressed[1][1] = 1'b1;
        wait_code("press5", 5'h15, 27);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (row_out !== 4'b1101) bad++;
        end
        chk("row_held5", bad, 0);
        chk("ev5", ev_cnt - ev0, 1);
        pressed[1][1] = 1'b0;
        wait_code("rel5", 5'h05, 11);
        chk("row_after_rel", row_out, 4'b1011);

        // '#' : row3 col2, bouncing 3 on / 3 off for 20 clocks
        ev0 = ev_cnt;
        for (int i = 0; i < 20; i++) begin
            pressed[3][2] = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        chk("bounce_noev", ev_cnt - ev0, 0);
        chk("bounce_code", key_code, 5'h05);
        pressed[3][2] = 1'b1;
        wait_code("hash", 5'h1F, 40);
        cyc(20);
        chk("hash_ev", ev_cnt - ev0, 1);
        pressed[3][2] = 1'b0;
        wait_code("rel_hash", 5'h0F, 11);

        // '1' and '3' together, then '9' on another row while held
        ev0 = ev_cnt;
        pressed[0][0] = 1'b1;
        pressed[0][2] = 1'b1;
        wait_code("combo13", 5'h11, 27);
        cyc(2);
        chk("combo_ev", ev_cnt - ev0, 1);
        ev1 = ev_cnt;
        pressed[2][2] = 1'b1;
        cyc(60);
        chk("add9_code", key_code, 5'h11);
        chk("add9_noev", ev_cnt - ev1, 0);
        pressed = '0;
        wait_code("rel13", 5'h01, 11);

        // 'D' : reset while held, then re-detection
        pressed[3][3] = 1'b1;
        wait_code("pressD", 5'h1D, 27);
        cyc(5);
        ev0 = ev_cnt;
        reset_n = 1'b0;
        #1;
        chk("midrst_code", key_code, 5'h00);
        chk("midrst_row", row_out, 4'b1110);
        cyc(3);
        reset_n = 1'b1;
        wait_code("redetD", 5'h1D, 30);
        cyc(3);
        chk("redetD_ev", ev_cnt - ev0, 1);
        pressed[3][3] = 1'b0;
        wait_code("relD", 5'h0D, 11);

`ifdef KEYPAD_IRQ_EN
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("irq_clrD", irq, 1'b0);
        // '0' : row3 col1
        pressed[3][1] = 1'b1;
        wait_code("press0", 5'h10, 27);
        cyc(1);
        chk("irq_set", irq, 1'b1);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("irq_ack", irq, 1'b0);
        pressed[3][1] = 1'b0;
        wait_code("rel0", 5'h00, 11);
        pressed[3][1] = 1'b1;
        begin
            int n = 0;
            while (key_event !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        chk("ev_seen", key_event, 1'b1);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("irq_set_wins", irq, 1'b1);
        cyc(1);
        chk("irq_sticky", irq, 1'b1);
        pressed = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
